// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: ALU operation codes, forwarding selects and
// the EX/MEM flag bundle used by the execute stage.
package mips_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0101;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch_taken;
        logic zero;
        logic overflow;
        logic illegal;
    } ex_flags_t;

    // Select 2'b11 is unused by the hazard unit and falls back to the ID/EX value.
    function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                            input logic [31:0] id_val,
                                            input logic [31:0] exmem_val,
                                            input logic [31:0] memwb_val);
        logic [31:0] val;
        case (sel)
            FWD_EXMEM: val = exmem_val;
            FWD_MEMWB: val = memwb_val;
            FWD_NONE:  val = id_val;
            default:   val = id_val;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX/MEM bundle of the execute stage. The forwarding signals exist
// only when FORWARDING_EN is defined.
interface ex_stage_if;

    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [3:0]  alu_signal;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic        alu_src;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic [31:0] pc_plus4;
`ifdef FORWARDING_EN
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] wb_data;
`endif

    logic        ex_valid;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_dest;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        ex_zero;
    logic        ex_overflow;
    logic        ex_illegal;

    modport master (
`ifdef FORWARDING_EN
        output fwd_a, fwd_b, wb_data,
`endif
        output in_valid, stall, flush, alu_signal, rs_data, rt_data, imm,
        output alu_src, dest, reg_write, mem_read, mem_write, branch, pc_plus4,
        input  ex_valid, ex_result, ex_store_data, ex_dest, ex_reg_write,
        input  ex_mem_read, ex_mem_write, ex_branch_taken, ex_branch_target,
        input  ex_zero, ex_overflow, ex_illegal
    );

    modport slave (
`ifdef FORWARDING_EN
        input  fwd_a, fwd_b, wb_data,
`endif
        input  in_valid, stall, flush, alu_signal, rs_data, rt_data, imm,
        input  alu_src, dest, reg_write, mem_read, mem_write, branch, pc_plus4,
        output ex_valid, ex_result, ex_store_data, ex_dest, ex_reg_write,
        output ex_mem_read, ex_mem_write, ex_branch_taken, ex_branch_target,
        output ex_zero, ex_overflow, ex_illegal
    );

endinterface

// File: rtl/alu_core.sv
// Combinational 32-bit ALU of the execute stage: add/sub with signed overflow,
// and/or, signed slt; unknown codes flag illegal and yield zero.
module alu_core
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic        illegal
);

    logic [31:0] sum_s;
    logic [31:0] diff_s;

    assign sum_s  = a + b;
    assign diff_s = a - b;

    // Operation select; slt uses a true signed compare so it is immune to sub overflow.
    always_comb begin
        result   = 32'd0;
        overflow = 1'b0;
        illegal  = 1'b0;
        case (op)
            ALU_ADD: begin
                result   = sum_s;
                overflow = (a[31] == b[31]) && (sum_s[31] != a[31]);
            end
            ALU_SUB: begin
                result   = diff_s;
                overflow = (a[31] != b[31]) && (diff_s[31] != a[31]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'd0, ($signed(a) < $signed(b))};
            default: illegal = 1'b1;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand selection, ALU, branch resolution and the EX/MEM
// register with flush > stall > load priority. Build option: FORWARDING_EN.
module ex_stage
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    ex_stage_if.slave  bus
);

    logic [31:0] op_a_s;
    logic [31:0] rt_fwd_s;
    logic [31:0] op_b_s;
    logic [31:0] alu_result_s;
    logic        alu_zero_s;
    logic        alu_overflow_s;
    logic        alu_illegal_s;
    logic [31:0] branch_target_s;
    ex_flags_t   flags_next_s;

    logic [31:0] ex_result_r;
    logic [31:0] ex_store_data_r;
    logic [4:0]  ex_dest_r;
    logic [31:0] ex_branch_target_r;
    ex_flags_t   flags_r;

    // Operand selection; forwarding applies to rt before the immediate mux.
    always_comb begin
`ifdef FORWARDING_EN
        op_a_s   = fwd_mux(bus.fwd_a, bus.rs_data, ex_result_r, bus.wb_data);
        rt_fwd_s = fwd_mux(bus.fwd_b, bus.rt_data, ex_result_r, bus.wb_data);
`else
        op_a_s   = bus.rs_data;
        rt_fwd_s = bus.rt_data;
`endif
        op_b_s   = bus.alu_src ? bus.imm : rt_fwd_s;
    end

    alu_core u_alu (
        .a        (op_a_s),
        .b        (op_b_s),
        .op       (bus.alu_signal),
        .result   (alu_result_s),
        .zero     (alu_zero_s),
        .overflow (alu_overflow_s),
        .illegal  (alu_illegal_s)
    );

    assign branch_target_s = bus.pc_plus4 + {bus.imm[29:0], 2'b00};

    // Flags for a loaded slot; a bubble clears all of them.
    always_comb begin
        flags_next_s              = '0;
        flags_next_s.valid        = bus.in_valid;
        flags_next_s.reg_write    = bus.in_valid & bus.reg_write & ~alu_illegal_s & ~alu_overflow_s;
        flags_next_s.mem_read     = bus.in_valid & bus.mem_read  & ~alu_illegal_s;
        flags_next_s.mem_write    = bus.in_valid & bus.mem_write & ~alu_illegal_s;
        flags_next_s.branch_taken = bus.in_valid & bus.branch & alu_zero_s;
        flags_next_s.zero         = bus.in_valid & alu_zero_s;
        flags_next_s.overflow     = bus.in_valid & alu_overflow_s;
        flags_next_s.illegal      = bus.in_valid & alu_illegal_s;
    end

    // EX/MEM register: a flushed slot behaves like a bubble while its data holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r            <= '0;
            ex_result_r        <= 32'd0;
            ex_store_data_r    <= 32'd0;
            ex_dest_r          <= 5'd0;
            ex_branch_target_r <= 32'd0;
        end else if (bus.flush) begin
            flags_r            <= '0;
        end else if (!bus.stall) begin
            flags_r            <= flags_next_s;
            ex_result_r        <= alu_result_s;
            ex_store_data_r    <= rt_fwd_s;
            ex_dest_r          <= bus.dest;
            ex_branch_target_r <= branch_target_s;
        end
    end

    assign bus.ex_valid         = flags_r.valid;
    assign bus.ex_reg_write     = flags_r.reg_write;
    assign bus.ex_mem_read      = flags_r.mem_read;
    assign bus.ex_mem_write     = flags_r.mem_write;
    assign bus.ex_branch_taken  = flags_r.branch_taken;
    assign bus.ex_zero          = flags_r.zero;
    assign bus.ex_overflow      = flags_r.overflow;
    assign bus.ex_illegal       = flags_r.illegal;
    assign bus.ex_result        = ex_result_r;
    assign bus.ex_store_data    = ex_store_data_r;
    assign bus.ex_dest          = ex_dest_r;
    assign bus.ex_branch_target = ex_branch_target_r;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus random traffic checked
// against an arithmetic reference model. Honours FORWARDING_EN when defined.
module tb_ex_stage;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    localparam longint S32_MAX = 64'sd2147483647;
    localparam longint S32_MIN = -64'sd2147483648;

    ex_stage_if ifc ();

    ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected EX/MEM contents
    logic        m_valid, m_rw, m_mr, m_mw, m_bt, m_zero, m_ovf, m_ill;
    logic [31:0] m_result, m_store, m_target;
    logic [4:0]  m_dest;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
        m_bt = 1'b0; m_zero = 1'b0; m_ovf = 1'b0; m_ill = 1'b0;
        m_result = 32'd0; m_store = 32'd0; m_target = 32'd0; m_dest = 5'd0;
    endtask

    task automatic model_edge();
        logic [31:0] a, rt, b, res;
        logic        ovf, ill;
        longint      sa, sb, full;
        if (ifc.flush) begin
            m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
            m_bt = 1'b0; m_zero = 1'b0; m_ovf = 1'b0; m_ill = 1'b0;
        end else if (!ifc.stall) begin
            a  = ifc.rs_data;
            rt = ifc.rt_data;
`ifdef FORWARDING_EN
            if (ifc.fwd_a == 2'b10) a = m_result;
            else if (ifc.fwd_a == 2'b01) a = ifc.wb_data;
            if (ifc.fwd_b == 2'b10) rt = m_result;
            else if (ifc.fwd_b == 2'b01) rt = ifc.wb_data;
`endif
            b   = ifc.alu_src ? ifc.imm : rt;
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            res = 32'd0; ovf = 1'b0; ill = 1'b0;
            case (ifc.alu_signal)
                4'd0: begin full = sa + sb; res = full[31:0]; ovf = (full > S32_MAX) || (full < S32_MIN); end
                4'd1: begin full = sa - sb; res = full[31:0]; ovf = (full > S32_MAX) || (full < S32_MIN); end
                4'd2: res = a & b;
                4'd3: res = a | b;
                4'd5: res = (sa < sb) ? 32'd1 : 32'd0;
                default: ill = 1'b1;
            endcase
            m_valid  = ifc.in_valid;
            m_result = res;
            m_store  = rt;
            m_dest   = ifc.dest;
            m_target = ifc.pc_plus4 + ifc.imm * 32'd4;
            m_zero   = ifc.in_valid && (res == 32'd0);
            m_ovf    = ifc.in_valid && ovf;
            m_ill    = ifc.in_valid && ill;
            m_rw     = ifc.in_valid && ifc.reg_write && !ill && !ovf;
            m_mr     = ifc.in_valid && ifc.mem_read && !ill;
            m_mw     = ifc.in_valid && ifc.mem_write && !ill;
            m_bt     = ifc.in_valid && ifc.branch && (res == 32'd0);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},  ifc.ex_valid,         m_valid);
        chk({tag, ".result"}, ifc.ex_result,        m_result);
        chk({tag, ".store"},  ifc.ex_store_data,    m_store);
        chk({tag, ".dest"},   ifc.ex_dest,          m_dest);
        chk({tag, ".rw"},     ifc.ex_reg_write,     m_rw);
        chk({tag, ".mr"},     ifc.ex_mem_read,      m_mr);
        chk({tag, ".mw"},     ifc.ex_mem_write,     m_mw);
        chk({tag, ".bt"},     ifc.ex_branch_taken,  m_bt);
        chk({tag, ".target"}, ifc.ex_branch_target, m_target);
        chk({tag, ".zero"},   ifc.ex_zero,          m_zero);
        chk({tag, ".ovf"},    ifc.ex_overflow,      m_ovf);
        chk({tag, ".ill"},    ifc.ex_illegal,       m_ill);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input logic v, input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] im, input logic src,
                          input logic [4:0] d, input logic rw, input logic mr,
                          input logic mw, input logic br, input logic [31:0] pc);
        ifc.in_valid = v; ifc.alu_signal = op; ifc.rs_data = rs; ifc.rt_data = rt;
        ifc.imm = im; ifc.alu_src = src; ifc.dest = d; ifc.reg_write = rw;
        ifc.mem_read = mr; ifc.mem_write = mw; ifc.branch = br; ifc.pc_plus4 = pc;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'($urandom_range(0, 7));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0] ops [7];
        ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd2; ops[3] = 4'd3;
        ops[4] = 4'd5; ops[5] = 4'd4; ops[6] = 4'd15;

        rst_n = 1'b0;
        ifc.stall = 1'b0;
        ifc.flush = 1'b0;
        set_in(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
`ifdef FORWARDING_EN
        ifc.fwd_a = 2'b00; ifc.fwd_b = 2'b00; ifc.wb_data = 32'd0;
`endif
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        set_in(1'b1, 4'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40);
        cycle("add_ovf");
        chk("add_ovf_result", ifc.ex_result, 32'h80000000);
        chk("add_ovf_flag", ifc.ex_overflow, 32'd1);
        chk("add_ovf_rw", ifc.ex_reg_write, 32'd0);

        set_in(1'b1, 4'd1, 32'd5, 32'd5, 32'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h44);
        cycle("sub_zero");
        chk("sub_zero_result", ifc.ex_result, 32'd0);
        chk("sub_zero_flag", ifc.ex_zero, 32'd1);

        set_in(1'b1, 4'd5, 32'h80000000, 32'd1, 32'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h48);
        cycle("slt_neg");
        chk("slt_neg_result", ifc.ex_result, 32'd1);
        set_in(1'b1, 4'd5, 32'd1, 32'h80000000, 32'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4C);
        cycle("slt_pos");
        chk("slt_pos_result", ifc.ex_result, 32'd0);

        set_in(1'b1, 4'd2, 32'h0000F0F0, 32'h00000FF0, 32'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 32'h50);
        cycle("and");
        chk("and_result", ifc.ex_result, 32'h000000F0);
        ifc.alu_signal = 4'd3;
        cycle("or");
        chk("or_result", ifc.ex_result, 32'h0000FFF0);

        set_in(1'b1, 4'd1, 32'd7, 32'd7, 32'hFFFFFFFE, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
        cycle("beq_taken");
        chk("beq_taken", ifc.ex_branch_taken, 32'd1);
        chk("beq_target", ifc.ex_branch_target, 32'h000000F8);
        ifc.rt_data = 32'd6;
        cycle("beq_not");
        chk("beq_not_taken", ifc.ex_branch_taken, 32'd0);

        set_in(1'b1, 4'd0, 32'd2, 32'd3, 32'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200);
        cycle("pre_stall");
        ifc.stall = 1'b1;
        set_in(1'b1, 4'd1, 32'd100, 32'd1, 32'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h204);
        cycle("stall1");
        chk("stall1_result", ifc.ex_result, 32'd5);
        cycle("stall2");
        chk("stall2_valid", ifc.ex_valid, 32'd1);
        ifc.flush = 1'b1;
        cycle("flush");
        chk("flush_valid", ifc.ex_valid, 32'd0);
        chk("flush_mw", ifc.ex_mem_write, 32'd0);
        chk("flush_result", ifc.ex_result, 32'd5);
        ifc.flush = 1'b0;
        ifc.stall = 1'b0;

        set_in(1'b1, 4'b0100, 32'd3, 32'd4, 32'd0, 1'b0, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 32'h300);
        cycle("illegal");
        chk("illegal_flag", ifc.ex_illegal, 32'd1);
        chk("illegal_result", ifc.ex_result, 32'd0);
        chk("illegal_rw", ifc.ex_reg_write, 32'd0);

        set_in(1'b0, 4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 32'h304);
        cycle("bubble");

`ifdef FORWARDING_EN
        set_in(1'b1, 4'd0, 32'd8, 32'd8, 32'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h400);
        cycle("fwd_src");
        chk("fwd_src_result", ifc.ex_result, 32'h10);
        set_in(1'b1, 4'd0, 32'h1234, 32'd1, 32'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h404);
        ifc.fwd_a = 2'b10;
        cycle("fwd_a");
        chk("fwd_a_result", ifc.ex_result, 32'h11);
        set_in(1'b1, 4'd0, 32'd1, 32'h55, 32'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 32'h408);
        ifc.fwd_a = 2'b00; ifc.fwd_b = 2'b01; ifc.wb_data = 32'd3;
        cycle("fwd_b");
        chk("fwd_b_result", ifc.ex_result, 32'd4);
        chk("fwd_b_store", ifc.ex_store_data, 32'd3);
        ifc.fwd_b = 2'b00;
`endif

        for (int i = 0; i < 300; i++) begin
            set_in(($urandom_range(0, 4) != 0), ops[$urandom_range(0, 6)], rand_operand(),
                   rand_operand(), rand_operand(), 1'($urandom), 5'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
            ifc.stall = ($urandom_range(0, 7) == 0);
            ifc.flush = ($urandom_range(0, 9) == 0);
`ifdef FORWARDING_EN
            ifc.fwd_a = 2'($urandom); ifc.fwd_b = 2'($urandom); ifc.wb_data = rand_operand();
`endif
            cycle("rand");
        end

        ifc.flush = 1'b0;
        ifc.stall = 1'b1;
        set_in(1'b1, 4'd3, 32'hFFFF0000, 32'h0000FFFF, 32'd0, 1'b0, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0, 32'h500);
        ifc.stall = 1'b0;
        cycle("pre_reset");
        ifc.stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("mid_reset");
        chk("mid_reset_result", ifc.ex_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ifc.stall = 1'b0;
        cycle("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
